// File: rtl/mem_arbiter_if.sv
// Bus bundle between the CPU-side ports, the arbiter and the halfword memory
// controller.
//   IF  : i_if_req/i_if_mode/i_if_addr in, o_if_gnt/o_if_rvalid/o_if_rdata out
//   LS  : i_ls_req/i_ls_we/i_ls_mode/i_ls_addr/i_ls_wdata in,
//         o_ls_gnt/o_ls_rvalid/o_ls_rdata out
//   MC  : o_mc_addr/o_mc_data/o_mc_wr_mode/o_mc_rd_mode out, i_mc_data in
// Directions are named from the arbiter's point of view. The arbiter uses the
// slave modport; the CPU/memory side (or a testbench) uses the master modport.
interface mem_arbiter_if #(
    parameter int ADDR_WIDTH = 13
);
    logic                  i_if_req;
    logic [1:0]            i_if_mode;
    logic [ADDR_WIDTH-1:0] i_if_addr;
    logic                  o_if_gnt;
    logic                  o_if_rvalid;
    logic [31:0]           o_if_rdata;

    logic                  i_ls_req;
    logic                  i_ls_we;
    logic [1:0]            i_ls_mode;
    logic [ADDR_WIDTH-1:0] i_ls_addr;
    logic [31:0]           i_ls_wdata;
    logic                  o_ls_gnt;
    logic                  o_ls_rvalid;
    logic [31:0]           o_ls_rdata;

    logic [ADDR_WIDTH-1:0] o_mc_addr;
    logic [31:0]           o_mc_data;
    logic [1:0]            o_mc_wr_mode;
    logic [1:0]            o_mc_rd_mode;
    logic [31:0]           i_mc_data;

    modport slave (
        input  i_if_req, i_if_mode, i_if_addr,
        output o_if_gnt, o_if_rvalid, o_if_rdata,
        input  i_ls_req, i_ls_we, i_ls_mode, i_ls_addr, i_ls_wdata,
        output o_ls_gnt, o_ls_rvalid, o_ls_rdata,
        output o_mc_addr, o_mc_data, o_mc_wr_mode, o_mc_rd_mode,
        input  i_mc_data
    );

    modport master (
        output i_if_req, i_if_mode, i_if_addr,
        input  o_if_gnt, o_if_rvalid, o_if_rdata,
        output i_ls_req, i_ls_we, i_ls_mode, i_ls_addr, i_ls_wdata,
        input  o_ls_gnt, o_ls_rvalid, o_ls_rdata,
        input  o_mc_addr, o_mc_data, o_mc_wr_mode, o_mc_rd_mode,
        output i_mc_data
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one halfword memory controller between the instruction
// fetch port (IF) and the load/store port (LS). LS has priority; a starvation
// counter forces an IF grant after STARVE_LIMIT consecutive LS grants taken
// while IF was waiting. 32-bit accesses occupy two controller cycles; read
// data is routed back to the owning port through a 2-deep tag pipe.
// Ports:
//   clk  - clock, all state on rising edge
//   rst  - synchronous reset, active high
//   bus  - mem_arbiter_if.slave (IF port, LS port, memory-controller side)
module mem_arbiter #(
    parameter int MEM_DEPTH    = 2**12,
    parameter int STARVE_LIMIT = 4
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);
    localparam int ADDR_WIDTH = $clog2(MEM_DEPTH * 2);
    localparam int CNT_W      = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    localparam logic [1:0] MODE_NONE = 2'd0;
    localparam logic [1:0] MODE_16   = 2'd1;
    localparam logic [1:0] MODE_32   = 2'd2;

    typedef enum logic {IDLE, SECOND} state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      starve_q, starve_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           data_q, data_d;
    logic                  sec_wr_q, sec_wr_d;

    // Read-return tags. The stage a tag enters encodes the access size:
    // 8/16-bit reads enter p1 directly, 32-bit reads enter p0 one cycle earlier.
    logic                  vld_p0_q, vld_p0_d, own_p0_q, own_p0_d;  // own: 1=LS, 0=IF
    logic                  vld_p1_q, vld_p1_d, own_p1_q, own_p1_d;

    logic                  if_rvalid_q, ls_rvalid_q;
    logic [31:0]           if_rdata_q, ls_rdata_q;

    logic                  ls_valid, if_valid, gnt_ls, gnt_if;
    logic [1:0]            wr_mode, rd_mode;
    logic [ADDR_WIDTH-1:0] mc_addr;
    logic [31:0]           mc_data;

    assign ls_valid = bus.i_ls_req && (bus.i_ls_mode != MODE_NONE);
    assign if_valid = bus.i_if_req && (bus.i_if_mode == MODE_16 || bus.i_if_mode == MODE_32);

    always_comb begin
        state_d  = state_q;
        starve_d = starve_q;
        sec_wr_d = sec_wr_q;
        gnt_ls   = 1'b0;
        gnt_if   = 1'b0;
        wr_mode  = MODE_NONE;
        rd_mode  = MODE_NONE;
        mc_addr  = addr_q;
        mc_data  = data_q;
        vld_p0_d = 1'b0;
        own_p0_d = 1'b0;
        vld_p1_d = vld_p0_q;
        own_p1_d = own_p0_q;

        if (state_q == SECOND) begin
            // Second half of a 32-bit access: address/data held, only a store
            // keeps the write strobe asserted.
            state_d = IDLE;
            wr_mode = sec_wr_q ? MODE_32 : MODE_NONE;
        end else if (ls_valid && !(if_valid && starve_q == CNT_MAX)) begin
            gnt_ls  = 1'b1;
            mc_addr = bus.i_ls_addr;
            mc_data = bus.i_ls_wdata;
            if (bus.i_ls_we) begin
                wr_mode = bus.i_ls_mode;
            end else begin
                rd_mode = bus.i_ls_mode;
                if (bus.i_ls_mode == MODE_32) begin
                    vld_p0_d = 1'b1;
                    own_p0_d = 1'b1;
                end else begin
                    vld_p1_d = 1'b1;
                    own_p1_d = 1'b1;
                end
            end
            if (bus.i_ls_mode == MODE_32) begin
                state_d  = SECOND;
                sec_wr_d = bus.i_ls_we;
            end
        end else if (if_valid) begin
            // Fetches carry no write data; o_mc_data keeps its previous value.
            gnt_if  = 1'b1;
            mc_addr = bus.i_if_addr;
            rd_mode = bus.i_if_mode;
            if (bus.i_if_mode == MODE_32) begin
                state_d  = SECOND;
                sec_wr_d = 1'b0;
                vld_p0_d = 1'b1;
            end else begin
                vld_p1_d = 1'b1;
            end
        end

        addr_d = mc_addr;
        data_d = mc_data;

        // Counts LS grants won while a valid fetch waited; any fetch grant or
        // an absent fetch request clears it.
        if (gnt_if || !if_valid) begin
            starve_d = '0;
        end else if (gnt_ls && starve_q != CNT_MAX) begin
            starve_d = starve_q + 1'b1;
        end

        if (rst) begin
            gnt_ls  = 1'b0;
            gnt_if  = 1'b0;
            wr_mode = MODE_NONE;
            rd_mode = MODE_NONE;
            mc_addr = '0;
            mc_data = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            starve_q    <= '0;
            addr_q      <= '0;
            data_q      <= '0;
            sec_wr_q    <= 1'b0;
            vld_p0_q    <= 1'b0;
            own_p0_q    <= 1'b0;
            vld_p1_q    <= 1'b0;
            own_p1_q    <= 1'b0;
            if_rvalid_q <= 1'b0;
            ls_rvalid_q <= 1'b0;
            if_rdata_q  <= '0;
            ls_rdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            starve_q    <= starve_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            sec_wr_q    <= sec_wr_d;
            vld_p0_q    <= vld_p0_d;
            own_p0_q    <= own_p0_d;
            vld_p1_q    <= vld_p1_d;
            own_p1_q    <= own_p1_d;
            // A tag in p1 means the controller is presenting that read's data now.
            if_rvalid_q <= vld_p1_q && !own_p1_q;
            ls_rvalid_q <= vld_p1_q && own_p1_q;
            if (vld_p1_q && !own_p1_q) begin
                if_rdata_q <= bus.i_mc_data;
            end
            if (vld_p1_q && own_p1_q) begin
                ls_rdata_q <= bus.i_mc_data;
            end
        end
    end

    assign bus.o_if_gnt     = gnt_if;
    assign bus.o_ls_gnt     = gnt_ls;
    assign bus.o_if_rvalid  = if_rvalid_q;
    assign bus.o_if_rdata   = if_rdata_q;
    assign bus.o_ls_rvalid  = ls_rvalid_q;
    assign bus.o_ls_rdata   = ls_rdata_q;
    assign bus.o_mc_addr    = mc_addr;
    assign bus.o_mc_data    = mc_data;
    assign bus.o_mc_wr_mode = wr_mode;
    assign bus.o_mc_rd_mode = rd_mode;
endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: directed scenarios with literal expectations,
// then randomized traffic, all checked every cycle against a transaction-level
// model (grant rules, a queue of scheduled read returns, held bus values).
module tb_mem_arbiter;
    localparam int AW    = 13;
    localparam int LIMIT = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_WIDTH(AW)) bus ();

    mem_arbiter #(.MEM_DEPTH(4096), .STARVE_LIMIT(LIMIT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct { int due; bit ls; } ret_t;
    ret_t          rq[$];
    int            cyc = 0;
    bit            m_busy = 0, m_sec_store = 0;
    int            m_cnt = 0;
    logic [AW-1:0] m_addr = '0;
    logic [31:0]   m_data = '0, m_if_rdata = '0, m_ls_rdata = '0, prev_mc = '0;

    task automatic model_cycle();
        logic          e_ifg, e_lsg;
        logic [1:0]    e_wr, e_rd;
        logic [AW-1:0] e_addr;
        logic [31:0]   e_data;
        bit            e_ifrv, e_lsrv, ifv, lsv;
        int            lat;
        e_ifrv = 0;
        e_lsrv = 0;
        while (rq.size() > 0 && rq[0].due == cyc) begin
            if (rq[0].ls) begin e_lsrv = 1; m_ls_rdata = prev_mc; end
            else          begin e_ifrv = 1; m_if_rdata = prev_mc; end
            void'(rq.pop_front());
        end
        check("if_rvalid", 32'(bus.o_if_rvalid), 32'(e_ifrv));
        check("ls_rvalid", 32'(bus.o_ls_rvalid), 32'(e_lsrv));
        check("if_rdata", bus.o_if_rdata, m_if_rdata);
        check("ls_rdata", bus.o_ls_rdata, m_ls_rdata);

        e_ifg = 0; e_lsg = 0; e_wr = 0; e_rd = 0; e_addr = m_addr; e_data = m_data;
        ifv = bus.i_if_req && (bus.i_if_mode == 2'd1 || bus.i_if_mode == 2'd2);
        lsv = bus.i_ls_req && (bus.i_ls_mode != 2'd0);
        if (rst) begin
            e_addr = '0; e_data = '0;
            rq.delete();
            m_busy = 0; m_cnt = 0; m_addr = '0; m_data = '0;
            m_if_rdata = '0; m_ls_rdata = '0;
        end else if (m_busy) begin
            m_busy = 0;
            if (m_sec_store) e_wr = 2'd2;
            if (!ifv) m_cnt = 0;
        end else begin
            if (lsv && !(ifv && m_cnt == LIMIT)) begin
                e_lsg = 1; e_addr = bus.i_ls_addr; e_data = bus.i_ls_wdata;
                if (bus.i_ls_we) e_wr = bus.i_ls_mode;
                else begin
                    e_rd = bus.i_ls_mode;
                    lat = (bus.i_ls_mode == 2'd2) ? 3 : 2;
                    rq.push_back('{due: cyc + lat, ls: 1'b1});
                end
                m_busy = (bus.i_ls_mode == 2'd2);
                m_sec_store = bus.i_ls_we;
                m_cnt = ifv ? ((m_cnt + 1 > LIMIT) ? LIMIT : m_cnt + 1) : 0;
            end else if (ifv) begin
                e_ifg = 1; e_addr = bus.i_if_addr; e_rd = bus.i_if_mode;
                lat = (bus.i_if_mode == 2'd2) ? 3 : 2;
                rq.push_back('{due: cyc + lat, ls: 1'b0});
                m_busy = (bus.i_if_mode == 2'd2);
                m_sec_store = 0;
                m_cnt = 0;
            end else begin
                m_cnt = 0;
            end
            m_addr = e_addr;
            m_data = e_data;
        end
        check("if_gnt", 32'(bus.o_if_gnt), 32'(e_ifg));
        check("ls_gnt", 32'(bus.o_ls_gnt), 32'(e_lsg));
        check("mc_wr_mode", 32'(bus.o_mc_wr_mode), 32'(e_wr));
        check("mc_rd_mode", 32'(bus.o_mc_rd_mode), 32'(e_rd));
        check("mc_addr", 32'(bus.o_mc_addr), 32'(e_addr));
        check("mc_data", bus.o_mc_data, e_data);
        prev_mc = bus.i_mc_data;
        cyc++;
    endtask

    always @(negedge clk) model_cycle();

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        bus.i_if_req = 0; bus.i_if_mode = 0; bus.i_if_addr = '0;
        bus.i_ls_req = 0; bus.i_ls_we = 0; bus.i_ls_mode = 0;
        bus.i_ls_addr = '0; bus.i_ls_wdata = '0;
    endtask

    task automatic set_if(input logic [1:0] mode, input logic [AW-1:0] addr);
        bus.i_if_req = 1; bus.i_if_mode = mode; bus.i_if_addr = addr;
    endtask

    task automatic set_ls(input logic we, input logic [1:0] mode, input logic [AW-1:0] addr,
                          input logic [31:0] wdata);
        bus.i_ls_req = 1; bus.i_ls_we = we; bus.i_ls_mode = mode;
        bus.i_ls_addr = addr; bus.i_ls_wdata = wdata;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0] seq;
        bit         gi, gl;
        idle_all();
        bus.i_mc_data = 32'h0;
        rst = 1;
        repeat (3) step();
        @(negedge clk);
        check("reset if_rvalid", 32'(bus.o_if_rvalid), 32'h0);
        check("reset ls_rdata", bus.o_ls_rdata, 32'h0);
        check("reset mc_addr", 32'(bus.o_mc_addr), 32'h0);
        step();
        rst = 0;
        step();

        // 1: IF 16-bit read alone
        set_if(2'd1, 13'h010);
        bus.i_mc_data = 32'h1111_1111;
        @(negedge clk);
        check("t1 if_gnt", 32'(bus.o_if_gnt), 32'h1);
        check("t1 rd_mode", 32'(bus.o_mc_rd_mode), 32'h1);
        check("t1 addr", 32'(bus.o_mc_addr), 32'h010);
        step();
        idle_all();
        bus.i_mc_data = 32'hCAFE_1234;
        @(negedge clk);
        check("t1 no early rvalid", 32'(bus.o_if_rvalid), 32'h0);
        step();
        bus.i_mc_data = 32'h0;
        @(negedge clk);
        check("t1 if_rvalid", 32'(bus.o_if_rvalid), 32'h1);
        check("t1 if_rdata", bus.o_if_rdata, 32'hCAFE_1234);
        step();

        // 2: LS 32-bit store, IF waiting during second cycle
        set_ls(1'b1, 2'd2, 13'h020, 32'hDEAD_BEEF);
        @(negedge clk);
        check("t2 ls_gnt", 32'(bus.o_ls_gnt), 32'h1);
        check("t2 wr_mode T", 32'(bus.o_mc_wr_mode), 32'h2);
        check("t2 data T", bus.o_mc_data, 32'hDEAD_BEEF);
        step();
        idle_all();
        set_if(2'd1, 13'h030);
        @(negedge clk);
        check("t2 no gnt T+1", 32'(bus.o_if_gnt | bus.o_ls_gnt), 32'h0);
        check("t2 wr_mode T+1", 32'(bus.o_mc_wr_mode), 32'h2);
        check("t2 addr T+1", 32'(bus.o_mc_addr), 32'h020);
        step();
        @(negedge clk);
        check("t2 if_gnt T+2", 32'(bus.o_if_gnt), 32'h1);
        step();
        idle_all();
        repeat (3) begin
            @(negedge clk);
            check("t2 no ls_rvalid", 32'(bus.o_ls_rvalid), 32'h0);
            step();
        end

        // 3: starvation; both 16-bit requests held
        set_ls(1'b0, 2'd1, 13'h100, 32'h0);
        set_if(2'd1, 13'h200);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            seq[i] = bus.o_ls_gnt;
            check("t3 one gnt", 32'(bus.o_ls_gnt ^ bus.o_if_gnt), 32'h1);
            step();
        end
        check("t3 grant order", 32'(seq), 32'h0F);
        @(negedge clk);
        check("t3 ls after reset cnt", 32'(bus.o_ls_gnt), 32'h1);
        step();
        idle_all();
        repeat (3) step();

        // 4: LS 32-bit load, IF 16-bit pending
        set_ls(1'b0, 2'd2, 13'h040, 32'h0);
        set_if(2'd1, 13'h050);
        @(negedge clk);
        check("t4 rd_mode T", 32'(bus.o_mc_rd_mode), 32'h2);
        step();
        bus.i_ls_req = 0;
        bus.i_mc_data = 32'h0BAD_0BAD;
        @(negedge clk);
        check("t4 rd_mode T+1", 32'(bus.o_mc_rd_mode), 32'h0);
        step();
        bus.i_mc_data = 32'h4444_AAAA;
        @(negedge clk);
        check("t4 if_gnt T+2", 32'(bus.o_if_gnt), 32'h1);
        step();
        idle_all();
        bus.i_mc_data = 32'h5555_BBBB;
        @(negedge clk);
        check("t4 ls_rvalid T+3", 32'(bus.o_ls_rvalid), 32'h1);
        check("t4 ls_rdata", bus.o_ls_rdata, 32'h4444_AAAA);
        step();
        @(negedge clk);
        check("t4 if_rvalid T+4", 32'(bus.o_if_rvalid), 32'h1);
        check("t4 if_rdata", bus.o_if_rdata, 32'h5555_BBBB);
        step();

        // 5: reset during second cycle of a 32-bit load
        set_ls(1'b0, 2'd2, 13'h060, 32'h0);
        step();
        idle_all();
        set_if(2'd1, 13'h070);
        rst = 1;
        @(negedge clk);
        check("t5 rd_mode in rst", 32'(bus.o_mc_rd_mode), 32'h0);
        check("t5 gnt in rst", 32'(bus.o_if_gnt), 32'h0);
        step();
        @(negedge clk);
        check("t5 addr in rst", 32'(bus.o_mc_addr), 32'h0);
        step();
        rst = 0;
        @(negedge clk);
        check("t5 if_gnt after rst", 32'(bus.o_if_gnt), 32'h1);
        step();
        idle_all();
        repeat (4) begin
            @(negedge clk);
            check("t5 no ls_rvalid", 32'(bus.o_ls_rvalid), 32'h0);
            step();
        end

        // 6: invalid modes are never granted
        set_ls(1'b1, 2'd0, 13'h080, 32'h1234_5678);
        set_if(2'd3, 13'h090);
        repeat (4) begin
            @(negedge clk);
            check("t6 no gnt", 32'({bus.o_ls_gnt, bus.o_if_gnt}), 32'h0);
            check("t6 modes", 32'({bus.o_mc_wr_mode, bus.o_mc_rd_mode}), 32'h0);
            step();
        end
        idle_all();

        // Random traffic; requesters hold a valid request until granted.
        for (int n = 0; n < 4000; n++) begin
            @(negedge clk);
            gi = bus.o_if_gnt;
            gl = bus.o_ls_gnt;
            step();
            rst = ($urandom_range(0, 99) == 0);
            bus.i_mc_data = $urandom();
            if (gi || !(bus.i_if_req && (bus.i_if_mode == 2'd1 || bus.i_if_mode == 2'd2))) begin
                bus.i_if_req  = ($urandom_range(0, 2) != 0);
                bus.i_if_mode = 2'($urandom_range(0, 3));
                bus.i_if_addr = AW'($urandom());
            end
            if (gl || !(bus.i_ls_req && bus.i_ls_mode != 2'd0)) begin
                bus.i_ls_req   = ($urandom_range(0, 3) != 0);
                bus.i_ls_we    = 1'($urandom_range(0, 1));
                bus.i_ls_mode  = 2'($urandom_range(0, 3));
                bus.i_ls_addr  = AW'($urandom());
                bus.i_ls_wdata = $urandom();
            end
        end
        rst = 0;
        idle_all();
        repeat (5) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
